// File: rtl/alu_shift_seq.sv
// Multi-cycle barrel-shift sequencer. A shift of N positions is performed as N
// one-position ALU shifts. Each ALU result is fed back as the next operand.
// The ALU output is enabled only while the shared result bus is granted.
module alu_shift_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  kind,
  input  logic [31:0] operand,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic [3:0]  status,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        alu_oe,
  output logic [3:0]  alu_operation,
  output logic [31:0] alu_a,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_status
);

  // ALU opcodes; these values mirror include/alu_op.vh
  localparam logic [3:0] ALU_PASSA = 4'h0;
  localparam logic [3:0] ALU_SHL   = 4'h5;
  localparam logic [3:0] ALU_SHR   = 4'h6;
  localparam logic [3:0] ALU_ASHR  = 4'h7;

  localparam logic [1:0] KindShl  = 2'd0;
  localparam logic [1:0] KindShr  = 2'd1;
  localparam logic [1:0] KindAshr = 2'd2;
  localparam logic [1:0] KindIll  = 2'd3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  kind_q, kind_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  status_q, status_d;
  logic        carry;

  // Only the ALU carry flag is consumed (for SHL)
  logic unused_status;
  assign unused_status = ^{alu_status[3:2], alu_status[0]};

  // Carry of the current step: SHL takes the ALU's C, right shifts the bit shifted out
  assign carry = (kind_q == KindShl) ? alu_status[1] : acc_q[0];

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    err_d    = err_q;
    result_d = result_q;
    status_d = status_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d  = operand;
          cnt_d  = shamt;
          kind_d = kind;
          err_d  = 1'b0;
          if (kind == KindIll) begin
            err_d    = 1'b1;
            result_d = operand;
            status_d = 4'b0000;
            state_d  = StDone;
          end else if (shamt == 5'd0) begin
            result_d = operand;
            status_d = {operand[31], (operand == 32'd0), 2'b00};
            state_d  = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (bus_gnt) state_d = StShift;
      end
      StShift: begin
        // Without a grant the ALU is not driving the bus, so nothing is sampled
        if (bus_gnt) begin
          acc_d = alu_result;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            result_d = alu_result;
            status_d = {alu_result[31], (alu_result == 32'd0), carry, 1'b0};
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      kind_q   <= KindShl;
      err_q    <= 1'b0;
      result_q <= 32'd0;
      status_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      err_q    <= err_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  // ALU opcode: shift op only while stepping, pass-through otherwise
  always_comb begin
    alu_operation = ALU_PASSA;
    if (state_q == StShift) begin
      case (kind_q)
        KindShl:  alu_operation = ALU_SHL;
        KindShr:  alu_operation = ALU_SHR;
        KindAshr: alu_operation = ALU_ASHR;
        default:  alu_operation = ALU_PASSA;
      endcase
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign err     = (state_q == StDone) && err_q;
  assign bus_req = (state_q == StReq) || (state_q == StShift);
  assign alu_oe  = (state_q == StShift) && bus_gnt;
  assign alu_a   = acc_q;
  assign result  = result_q;
  assign status  = status_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: a one-bit-shift ALU model drives the
// DUT, and results are compared with shifts computed arithmetically.
module tb_alu_shift_seq;

  localparam logic [3:0] ALU_PASSA = 4'h0;
  localparam logic [3:0] ALU_SHL   = 4'h5;
  localparam logic [3:0] ALU_SHR   = 4'h6;
  localparam logic [3:0] ALU_ASHR  = 4'h7;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, err, bus_req, bus_gnt, alu_oe;
  logic [1:0]  kind;
  logic [31:0] operand, result, alu_a, alu_result;
  logic [4:0]  shamt;
  logic [3:0]  status, alu_operation, alu_status;

  int checks = 0;
  int errors = 0;

  alu_shift_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .kind         (kind),
    .operand      (operand),
    .shamt        (shamt),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .result       (result),
    .status       (status),
    .bus_req      (bus_req),
    .bus_gnt      (bus_gnt),
    .alu_oe       (alu_oe),
    .alu_operation(alu_operation),
    .alu_a        (alu_a),
    .alu_result   (alu_result),
    .alu_status   (alu_status)
  );

  always #5 clk = ~clk;

  // Single-bit-shift ALU
  always_comb begin
    logic c;
    c = 1'b0;
    alu_result = alu_a;
    case (alu_operation)
      ALU_SHL:  begin alu_result = alu_a << 1; c = alu_a[31]; end
      ALU_SHR:  begin alu_result = alu_a >> 1; c = alu_a[0]; end
      ALU_ASHR: begin alu_result = {alu_a[31], alu_a[31:1]}; c = alu_a[0]; end
      default:  alu_result = alu_a;
    endcase
    alu_status = {alu_result[31], (alu_result == 32'd0), c, 1'b0};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {status, result} from whole-word arithmetic
  function automatic logic [35:0] ref_op(input logic [1:0] k, input logic [31:0] op,
                                         input logic [4:0] sh);
    logic signed [31:0] s;
    logic [31:0] r;
    logic        c;
    int          n;
    n = int'(sh);
    if (k == 2'd3) return {4'b0000, op};
    if (n == 0) return {op[31], (op == 32'd0), 2'b00, op};
    s = op;
    case (k)
      2'd0:    begin r = op << n; c = op[32 - n]; end
      2'd1:    begin r = op >> n; c = op[n - 1]; end
      default: begin r = s >>> n; c = op[n - 1]; end
    endcase
    return {r[31], (r == 32'd0), c, 1'b0, r};
  endfunction

  // stall_mode: 0 always granted, 1 random grants, 2 scripted stalls
  task automatic run_op(input logic [1:0] k, input logic [31:0] op, input logic [4:0] sh,
                        input int stall_mode, input bit poke);
    bit          pat [0:255];
    int          need, grants, exp_done, got, oe_cnt, bad_oe;
    bit          req_seen, req_at_done, err_at_done;
    logic [35:0] exp;
    exp = ref_op(k, op, sh);
    need = (k == 2'd3 || sh == 5'd0) ? 0 : int'(sh) + 1;
    for (int i = 0; i < 256; i++) begin
      case (stall_mode)
        0:       pat[i] = 1'b1;
        1:       pat[i] = ($urandom_range(3) != 0);
        default: pat[i] = !(i inside {1, 2, 3, 5});
      endcase
    end
    // Done follows the cycle carrying the need-th grant (REQ grant + one per step)
    exp_done = 1;
    grants = 0;
    if (need > 0) begin
      for (int i = 1; i < 256; i++) begin
        if (pat[i]) grants++;
        if (grants == need) begin exp_done = i + 1; break; end
      end
    end
    @(negedge clk);
    start = 1'b1; kind = k; operand = op; shamt = sh; bus_gnt = $urandom_range(1);
    got = -1; oe_cnt = 0; bad_oe = 0; req_seen = 0; req_at_done = 0; err_at_done = 0;
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      start = poke && (i == 2);
      if (poke) begin
        operand = ~op; kind = 2'($urandom_range(2)); shamt = 5'($urandom);
      end
      bus_gnt = pat[i];
      #1;
      if (i == 1) check_eq("busy_after_start", 32'(busy), 32'd1);
      if (alu_oe) oe_cnt++;
      if (alu_oe && !bus_gnt) bad_oe++;
      if (bus_req) req_seen = 1;
      if (done) begin
        got = i; req_at_done = bus_req; err_at_done = err;
        break;
      end
    end
    check_eq("done_cycle", got, exp_done);
    check_eq("result", result, exp[31:0]);
    check_eq("status", 32'(exp[35:32]), 32'(status));
    check_eq("err", 32'(err_at_done), 32'(k == 2'd3));
    check_eq("bus_req_at_done", 32'(req_at_done), 32'd0);
    check_eq("bus_req_seen", 32'(req_seen), 32'(need > 0));
    check_eq("alu_oe_cycles", oe_cnt, (need > 0) ? int'(sh) : 0);
    check_eq("alu_oe_without_gnt", bad_oe, 0);
    @(negedge clk);
    start = 1'b0; bus_gnt = 1'b1;
    #1;
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("busy_after_done", 32'(busy), 32'd0);
    check_eq("result_held", result, exp[31:0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {27'd0, busy, done, err, bus_req, alu_oe}, 32'd0);
    check_eq({tag, "_result"}, result, 32'd0);
    check_eq({tag, "_status"}, 32'(status), 32'd0);
    check_eq({tag, "_alu_a"}, alu_a, 32'd0);
    check_eq({tag, "_alu_op"}, 32'(alu_operation), 32'(ALU_PASSA));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kind = 2'd0; operand = 32'd0; shamt = 5'd0; bus_gnt = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    run_op(2'd0, 32'h0000_0001, 5'd4, 0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 5'd31, 0, 1'b0);
    run_op(2'd1, 32'h0000_0003, 5'd2, 0, 1'b0);
    run_op(2'd0, 32'h8000_0001, 5'd1, 2, 1'b0);
    run_op(2'd0, 32'h0000_0000, 5'd0, 1, 1'b0);
    run_op(2'd3, 32'h1234_5678, 5'd7, 0, 1'b0);
    run_op(2'd1, 32'hF0F0_0000, 5'd5, 0, 1'b1);

    // Reset in the middle of SHIFT
    @(negedge clk);
    start = 1'b1; kind = 2'd0; operand = 32'h0000_00FF; shamt = 5'd10; bus_gnt = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("no_done_after_rst", {31'd0, done | busy}, 32'd0);
    end
    run_op(2'd0, 32'h0000_00FF, 5'd10, 0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      run_op(2'($urandom_range(3)), $urandom, 5'($urandom), 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
